// File: rtl/mbit_dffsr_stim.sv
// Stimulus sequencer for a WIDTH-bit set/clear flip-flop bank: sweeps every D/SET combination
// with an apply, clear-ramp and hold phase per step. Define MBIT_DFFSR_STIM_LOOP_EN to repeat sweeps.
module mbit_dffsr_stim #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned HOLD  = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               STOP,
  output logic [WIDTH-1:0]   D,
  output logic [WIDTH-1:0]   SET,
  output logic [WIDTH-1:0]   CLR,
  output logic [2*WIDTH-1:0] STEP,
  output logic               BUSY,
  output logic               DONE
);

  localparam int unsigned SW   = 2 * WIDTH;
  localparam int unsigned MAXC = (WIDTH > HOLD) ? WIDTH : HOLD;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] RampLast = CW'(WIDTH);
  localparam logic [CW-1:0] HoldLast = CW'(HOLD);
  localparam logic [SW-1:0] StepMax  = '1;

  typedef enum logic [1:0] {StIdle, StApply, StRamp, StHold} state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] set_q, set_d;
  logic [WIDTH-1:0] clr_q, clr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  // Cleared by reset; a START is only honoured once START has been seen low afterwards.
  logic             armed_q, armed_d;

  logic [SW-1:0]    step_inc;
  logic             go;

  function automatic logic [WIDTH-1:0] gray_of(input logic [SW-1:0] s);
    logic [WIDTH-1:0] g;
    g = s[SW-1:WIDTH];
    return g ^ (g >> 1);
  endfunction

  // Mask with the top k bits set.
  function automatic logic [WIDTH-1:0] clr_mask(input logic [CW-1:0] k);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if ((i + int'(k)) >= int'(WIDTH)) m[i] = 1'b1;
    end
    return m;
  endfunction

  assign step_inc = step_q + SW'(1);
  assign go       = START & ~STOP & armed_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    set_d   = set_q;
    clr_d   = clr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    armed_d = armed_q | ~START;

    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d = StApply;
          step_d  = '0;
          cnt_d   = '0;
          d_d     = '0;
          set_d   = '0;
          clr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      StApply: begin
        state_d = StRamp;
        cnt_d   = CW'(1);
        clr_d   = clr_mask(CW'(1));
      end
      StRamp: begin
        if (cnt_q == RampLast) begin
          state_d = StHold;
          cnt_d   = CW'(1);
          clr_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          clr_d = clr_mask(cnt_q + CW'(1));
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          cnt_d = '0;
          clr_d = '0;
          if (step_q == StepMax) begin
            done_d = 1'b1;
            step_d = '0;
            d_d    = '0;
            set_d  = '0;
`ifdef MBIT_DFFSR_STIM_LOOP_EN
            state_d = StApply;
            busy_d  = 1'b1;
`else
            state_d = StIdle;
            busy_d  = 1'b0;
`endif
          end else begin
            state_d = StApply;
            step_d  = step_inc;
            d_d     = step_inc[WIDTH-1:0];
            set_d   = gray_of(step_inc);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase

    // Abort overrides every active-state transition, including the end-of-sweep DONE.
    if (state_q != StIdle && STOP) begin
      state_d = StIdle;
      step_d  = '0;
      cnt_d   = '0;
      d_d     = '0;
      set_d   = '0;
      clr_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      step_q  <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
      set_q   <= '0;
      clr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      set_q   <= set_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      armed_q <= armed_d;
    end
  end

  assign D    = d_q;
  assign SET  = set_q;
  assign CLR  = clr_q;
  assign STEP = step_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_mbit_dffsr_stim.sv
// Directed bench for mbit_dffsr_stim: default instance (WIDTH=2, HOLD=4) plus a WIDTH=1, HOLD=1 one.
module tb_mbit_dffsr_stim;

  logic       clk, rst, start, stop;
  logic [1:0] d, set, clr;
  logic [3:0] step;
  logic       busy, done;

  logic       s_start, s_stop;
  logic [0:0] s_d, s_set, s_clr;
  logic [1:0] s_step;
  logic       s_busy, s_done;

  int checks = 0;
  int errors = 0;

  logic [1:0] clr_tab  [7] = '{2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [1:0] gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  mbit_dffsr_stim dut (
    .CLK(clk), .RST(rst), .START(start), .STOP(stop),
    .D(d), .SET(set), .CLR(clr), .STEP(step), .BUSY(busy), .DONE(done)
  );

  mbit_dffsr_stim #(.WIDTH(1), .HOLD(1)) dut_small (
    .CLK(clk), .RST(rst), .START(s_start), .STOP(s_stop),
    .D(s_d), .SET(s_set), .CLR(s_clr), .STEP(s_step), .BUSY(s_busy), .DONE(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; s_start = 1'b0; s_stop = 1'b0;
    tick(); tick();
    checks++;
    if ({d, set, clr, step} !== 10'd0) begin
      errors++; $display("FAIL reset_vectors: got %h expected 0", {d, set, clr, step});
    end
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", busy, done);
    end
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, done, step} !== 6'd0) begin
      errors++; $display("FAIL idle_after_reset: got %h expected 0", {busy, done, step});
    end
  endtask

  task automatic test_first_step();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if ({d, set, clr, step, busy} !== {2'b00, 2'b00, clr_tab[c-1], 4'd0, 1'b1}) begin
        errors++;
        $display("FAIL first_step c%0d: got d=%b set=%b clr=%b step=%0d busy=%b expected clr=%b",
                 c, d, set, clr, step, busy, clr_tab[c-1]);
      end
      tick();
    end
    checks++;
    if ({step, d, set, clr} !== {4'd1, 2'b01, 2'b00, 2'b00}) begin
      errors++; $display("FAIL step1_apply: got step=%0d d=%b set=%b clr=%b expected 1 01 00 00",
                         step, d, set, clr);
    end
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_full_sweep();
    logic [3:0] es;
    logic [1:0] ed, eset, eclr;
    int         ph;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 112; c++) begin
      es   = 4'((c - 1) / 7);
      ph   = (c - 1) % 7;
      ed   = es[1:0];
      eset = gray_tab[es[3:2]];
      eclr = clr_tab[ph];
      checks++;
      if ({step, d, set, clr, busy, done} !== {es, ed, eset, eclr, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL sweep c%0d: got step=%0d d=%b set=%b clr=%b busy=%b done=%b expected %0d %b %b %b 1 0",
                 c, step, d, set, clr, busy, done, es, ed, eset, eclr);
      end
      if (c == 50) start = 1'b1;
      if (c == 51) start = 1'b0;
      tick();
    end
`ifdef MBIT_DFFSR_STIM_LOOP_EN
    checks++;
    if ({step, d, set, clr, busy, done} !== {4'd0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1}) begin
      errors++; $display("FAIL sweep_wrap: got step=%0d clr=%b busy=%b done=%b expected 0 00 1 1",
                         step, clr, busy, done);
    end
    tick();
    checks++;
    if ({clr, busy, done} !== {2'b10, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sweep_wrap_next: got clr=%b busy=%b done=%b expected 10 1 0",
                         clr, busy, done);
    end
    stop = 1'b1; tick(); stop = 1'b0;
`else
    checks++;
    if ({step, d, set, clr, busy, done} !== {4'd0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1}) begin
      errors++; $display("FAIL sweep_done: got step=%0d clr=%b busy=%b done=%b expected 0 00 0 1",
                         step, clr, busy, done);
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL done_one_cycle: got busy=%b done=%b expected 0 0", busy, done);
    end
`endif
  endtask

  task automatic test_stop();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 36; c++) tick();
    checks++;
    if ({step, clr} !== {4'd5, 2'b10}) begin
      errors++; $display("FAIL stop_setup: got step=%0d clr=%b expected 5 10", step, clr);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    checks++;
    if ({d, set, clr, step, busy, done} !== 12'd0) begin
      errors++; $display("FAIL stop_abort: got d=%b set=%b clr=%b step=%0d busy=%b done=%b expected 0",
                         d, set, clr, step, busy, done);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({step, d, clr, busy} !== {4'd0, 2'b00, 2'b00, 1'b1}) begin
      errors++; $display("FAIL stop_restart: got step=%0d d=%b clr=%b busy=%b expected 0 00 00 1",
                         step, d, clr, busy);
    end
    tick();
    checks++;
    if (clr !== 2'b10) begin
      errors++; $display("FAIL restart_ramp: got clr=%b expected 10", clr);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    checks++;
    if ({busy, step} !== 5'd0) begin
      errors++; $display("FAIL stop_wins: got busy=%b step=%0d expected 0 0", busy, step);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL stop_wins_hold: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    checks++;
    if ({busy, clr, d} !== {1'b1, 2'b00, 2'b00}) begin
      errors++; $display("FAIL areset_setup: got busy=%b clr=%b expected 1 00", busy, clr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({d, set, clr, step, busy, done} !== 12'd0) begin
      errors++; $display("FAIL areset_async: got d=%b set=%b clr=%b step=%0d busy=%b expected 0",
                         d, set, clr, step, busy);
    end
    tick();
    #2 rst = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL areset_start_ignored: got busy=%b expected 0", busy);
    end
    tick();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({busy, step} !== {1'b1, 4'd0}) begin
      errors++; $display("FAIL areset_fresh_start: got busy=%b step=%0d expected 1 0", busy, step);
    end
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_small();
    logic [1:0] es;
    s_start = 1'b1; tick(); s_start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      es = 2'((c - 1) / 3);
      checks++;
      if ({s_step, s_d, s_set, s_clr, s_busy, s_done} !==
          {es, es[0], es[1], ((c - 1) % 3) == 1, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL small c%0d: got step=%0d d=%b set=%b clr=%b busy=%b done=%b expected step=%0d",
                 c, s_step, s_d, s_set, s_clr, s_busy, s_done, es);
      end
      tick();
    end
`ifdef MBIT_DFFSR_STIM_LOOP_EN
    checks++;
    if ({s_busy, s_done, s_step} !== {1'b1, 1'b1, 2'd0}) begin
      errors++; $display("FAIL small_wrap: got busy=%b done=%b expected 1 1", s_busy, s_done);
    end
    s_stop = 1'b1; tick(); s_stop = 1'b0;
`else
    checks++;
    if ({s_busy, s_done} !== 2'b01) begin
      errors++; $display("FAIL small_done: got busy=%b done=%b expected 0 1", s_busy, s_done);
    end
    tick();
    checks++;
    if (s_done !== 1'b0) begin
      errors++; $display("FAIL small_done_pulse: got done=%b expected 0", s_done);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_full_sweep();
    test_stop();
    test_async_reset();
    test_small();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbit_dffsr_stim.md
MBIT_DFFSR_STIM -- requirements
Module: mbit_dffsr_stim

Interface
REQ-001 Parameter WIDTH, default 2: bit width of the D/SET/CLR vectors; the legal range is 1..4.
REQ-002 Parameter HOLD, default 4: number of settle cycles per step with CLR=0; the legal range is 1..255.
REQ-003 The block SHALL have one clock, CLK, and an asynchronous active-high reset, RST.
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 RST  input  1  asynchronous active-high reset.
REQ-006 START  input  1  pulse that begins a sweep when the block is idle.
REQ-007 STOP  input  1  aborts an active sweep.
REQ-008 D  output  WIDTH  data vector for the downstream set/clear flip-flop bank.
REQ-009 SET  output  WIDTH  per-bit set vector for the downstream bank.
REQ-010 CLR  output  WIDTH  per-bit clear vector for the downstream bank.
REQ-011 STEP  output  2*WIDTH  index of the current step.
REQ-012 BUSY  output  1  high while a sweep is active.
REQ-013 DONE  output  1  one-cycle pulse at sweep completion.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, APPLY, RAMP and HOLD; all outputs SHALL be registered.
REQ-015 In IDLE: D=0, SET=0, CLR=0, STEP=0, BUSY=0.
REQ-016 When IDLE samples START=1 and STOP=0, the next cycle SHALL be APPLY with STEP=0; START SHALL be ignored outside IDLE.
REQ-017 In APPLY (1 cycle): D=STEP[WIDTH-1:0], SET=g^(g>>1) where g=STEP[2W-1:W] (Gray code), and CLR=0.
REQ-018 In RAMP (WIDTH cycles, k=1..WIDTH): CLR SHALL have its top k bits set (for WIDTH=2: 10, then 11); D and SET SHALL be held.
REQ-019 In HOLD (HOLD cycles): CLR=0; D and SET SHALL be held.
REQ-020 Each step SHALL last exactly 1+WIDTH+HOLD cycles; a sweep SHALL be 2^(2*WIDTH) steps (112 cycles at the defaults).
REQ-021 After the last HOLD cycle of a step with STEP<max, the FSM SHALL go to APPLY with STEP+1.
REQ-022 After the last HOLD cycle of step max, the FSM SHALL go to IDLE and DONE=1 for that first IDLE cycle only.
REQ-023 BUSY SHALL be 1 in APPLY, RAMP and HOLD.
REQ-024 STOP=1 sampled in any active state SHALL force IDLE outputs on the next cycle with no DONE pulse.
REQ-025 If STOP and START are high in the same cycle in IDLE, STOP SHALL win and the block SHALL remain IDLE.
REQ-026 The cycle counter SHALL be ceil(log2(max(WIDTH,HOLD)+1)) bits wide, and STEP arithmetic SHALL be modulo 2^(2*WIDTH).

Reset
REQ-027 RST=1 SHALL immediately (asynchronously) force IDLE, all outputs to 0 and all counters to 0, including in the middle of a sweep.
REQ-028 After RST is released, the block SHALL require a fresh START.

Configuration
REQ-029 Macro MBIT_DFFSR_STIM_LOOP_EN: when defined, after the last HOLD cycle of step max the FSM SHALL wrap to APPLY with STEP=0, BUSY SHALL stay 1, and DONE SHALL pulse during that wrap APPLY cycle; the sweep SHALL repeat until STOP or RST.
REQ-030 Without MBIT_DFFSR_STIM_LOOP_EN, the behaviour of REQ-022 applies and a single sweep runs per START.

Verification
REQ-031 Defaults, START pulse at cycle 0 -> cycles 1..7 show D=00, SET=00, CLR=00,10,11,00,00,00,00; STEP=1 at cycle 8 with D=01.
REQ-032 Full sweep -> the SET sequence per D-group is 00,01,11,10; BUSY is high for 112 cycles; DONE is high for 1 cycle at cycle 113.
REQ-033 STOP asserted during the RAMP of STEP=5 -> outputs are 0, BUSY=0 and DONE=0 on the next cycle; a later START restarts at STEP=0.
REQ-034 RST pulsed asynchronously mid-HOLD (between clock edges) -> outputs are 0 before the next edge; a START in the same cycle as RST release is ignored.
REQ-035 With MBIT_DFFSR_STIM_LOOP_EN -> at cycle 113, STEP=0, BUSY=1 and DONE=1 for one cycle; the second sweep is identical to the first.
REQ-036 WIDTH=1, HOLD=1 -> steps last 3 cycles, with CLR sequence 0,1,0; there are 4 steps; DONE is high at cycle 13.
